// File: rtl/clk_mon_pkg.sv
// Shared encodings and default constants for the clock frequency monitor
// (100 MHz system clock, monitored clock arriving as a divide-by-16 toggle).
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_LOST = 2'd0,
    ST_QUAL = 2'd1,
    ST_GOOD = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_GATE_CYCLES  = 100_000;
  localparam int unsigned DEF_EDGE_MIN     = 12_375;
  localparam int unsigned DEF_EDGE_MAX     = 12_625;
  localparam int unsigned DEF_GOOD_WINDOWS = 3;
  localparam int unsigned DEF_BAD_WINDOWS  = 2;
  localparam int unsigned DEF_STALL_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W        = 32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a history flop; emits a one-cycle pulse on
// every rising or falling transition of the asynchronous input.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync ^ prev;

endmodule

// File: rtl/clk_freq_monitor.sv
// Gate-window edge counter with a LOST/QUAL/GOOD qualification FSM.
// Optional stall detection is compiled in with CLK_MON_STALL_EN.
//
//   state | meaning
//   LOST  | monitored clock unusable, waiting for an in-range window
//   QUAL  | in-range windows seen, counting toward GOOD_WINDOWS
//   GOOD  | clock qualified, clk_good_o asserted
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int unsigned EDGE_MIN     = DEF_EDGE_MIN,
  parameter int unsigned EDGE_MAX     = DEF_EDGE_MAX,
  parameter int unsigned GOOD_WINDOWS = DEF_GOOD_WINDOWS,
  parameter int unsigned BAD_WINDOWS  = DEF_BAD_WINDOWS,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             mon_toggle_i,
  output logic             clk_good_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             cnt_valid_o,
  output logic [15:0]      fail_cnt_o
);

  localparam int unsigned GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned RUN_MAX = (GOOD_WINDOWS > BAD_WINDOWS) ? GOOD_WINDOWS : BAD_WINDOWS;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  logic              tgl_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic              last_gate;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_plus;
  logic [CNT_W-1:0]  win_cnt;
  logic              window_armed;
  logic              eval;
  logic              in_range;
  logic              stall_hit;

  mon_state_t        state, state_nx;
  logic [RUN_W-1:0]  good_run, good_nx, good_inc;
  logic [RUN_W-1:0]  bad_run, bad_nx, bad_inc;
  logic [15:0]       fail_nx;

  sync_edge_det u_sync (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .din   (mon_toggle_i),
    .pulse (tgl_edge)
  );

  assign last_gate = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  assign acc_plus  = (acc == {CNT_W{1'b1}}) ? acc : acc + CNT_W'(1);
  // An edge landing on the closing gate cycle still belongs to that window.
  assign win_cnt   = tgl_edge ? acc_plus : acc;
  assign in_range  = (win_cnt >= CNT_W'(EDGE_MIN)) && (win_cnt <= CNT_W'(EDGE_MAX));
  assign eval      = last_gate && window_armed;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      gate_cnt     <= '0;
      acc          <= '0;
      window_armed <= 1'b0;
    end else begin
      if (last_gate) begin
        gate_cnt     <= '0;
        acc          <= '0;
        window_armed <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (tgl_edge) acc <= acc_plus;
      end
    end
  end

`ifdef CLK_MON_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stall_cnt <= '0;
    end else if (tgl_edge) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_W'(STALL_CYCLES)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign stall_hit = (stall_cnt == STALL_W'(STALL_CYCLES));
`else
  assign stall_hit = 1'b0;
`endif

  assign good_inc = (state == ST_QUAL) ? good_run + RUN_W'(1) : RUN_W'(1);
  assign bad_inc  = bad_run + RUN_W'(1);

  always_comb begin
    state_nx = state;
    good_nx  = good_run;
    bad_nx   = bad_run;
    fail_nx  = fail_cnt_o;

    if (eval) begin
      case (state)
        ST_LOST, ST_QUAL: begin
          bad_nx = '0;
          if (!in_range) begin
            state_nx = ST_LOST;
            good_nx  = '0;
          end else if (good_inc >= RUN_W'(GOOD_WINDOWS)) begin
            state_nx = ST_GOOD;
            good_nx  = '0;
          end else begin
            state_nx = ST_QUAL;
            good_nx  = good_inc;
          end
        end
        ST_GOOD: begin
          good_nx = '0;
          if (in_range) begin
            bad_nx = '0;
          end else if (bad_inc >= RUN_W'(BAD_WINDOWS)) begin
            state_nx = ST_LOST;
            bad_nx   = '0;
            fail_nx  = sat_inc16(fail_cnt_o);
          end else begin
            bad_nx = bad_inc;
          end
        end
        default: begin
          state_nx = ST_LOST;
          good_nx  = '0;
          bad_nx   = '0;
        end
      endcase
    end

    // A stall preempts any window verdict taken in the same cycle.
    if (stall_hit && (state != ST_LOST)) begin
      state_nx = ST_LOST;
      good_nx  = '0;
      bad_nx   = '0;
      fail_nx  = (state == ST_GOOD) ? sat_inc16(fail_cnt_o) : fail_cnt_o;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= ST_LOST;
      good_run    <= '0;
      bad_run     <= '0;
      fail_cnt_o  <= '0;
      clk_good_o  <= 1'b0;
      edge_cnt_o  <= '0;
      cnt_valid_o <= 1'b0;
    end else begin
      state       <= state_nx;
      good_run    <= good_nx;
      bad_run     <= bad_nx;
      fail_cnt_o  <= fail_nx;
      clk_good_o  <= (state_nx == ST_GOOD);
      cnt_valid_o <= eval;
      if (eval) edge_cnt_o <= win_cnt;
    end
  end

  assign state_o = state;

endmodule
